// File: rtl/regfile_sb_pkg.sv
// Shared defaults and index/data types for the scoreboarded register file.
package regfile_sb_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NREAD = 2;
    localparam int DEF_IDXW  = $clog2(DEF_NREGS);

    typedef logic [DEF_IDXW-1:0]  reg_idx_t;
    typedef logic [DEF_WIDTH-1:0] data_word_t;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending tracking: the issue handshake, busy flags per read port,
// and a registered count of outstanding producers.
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int NREGS = DEF_NREGS,
    parameter  int NREAD = DEF_NREAD,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREAD-1:0][IDXW-1:0] rd_idx,
    output logic [NREAD-1:0]           rd_busy,
    input  logic                       iss_valid,
    input  logic [IDXW-1:0]            iss_idx,
    output logic                       iss_ready,
    input  logic                       wb_en,
    input  logic [IDXW-1:0]            wb_idx,
    output logic [IDXW:0]              pend_cnt
);
    localparam logic [IDXW:0] CNT_ONE = 1;

    logic [NREGS-1:0] pend_q, pend_d;
    logic [IDXW:0]    pend_cnt_q, pend_cnt_d;
    logic             iss_set, wb_clr;

    always_comb begin
        iss_ready = !rst && iss_valid &&
                    (iss_idx == '0 || !pend_q[iss_idx] || (wb_en && wb_idx == iss_idx));
        iss_set   = iss_ready && iss_idx != '0;
        wb_clr    = wb_en && wb_idx != '0 && pend_q[wb_idx];

        // Set applied after clear so a same-index claim leaves the bit at 1.
        pend_d = pend_q;
        if (wb_clr)  pend_d[wb_idx]  = 1'b0;
        if (iss_set) pend_d[iss_idx] = 1'b1;

        // A set on a pending index always coincides with a clear of it, so
        // set/clear imbalance alone tracks popcount.
        pend_cnt_d = pend_cnt_q;
        if (iss_set && !wb_clr)      pend_cnt_d = pend_cnt_q + CNT_ONE;
        else if (wb_clr && !iss_set) pend_cnt_d = pend_cnt_q - CNT_ONE;
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NREAD; i++)
            rd_busy[i] = pend_q[rd_idx[i]] && !(wb_en && wb_idx == rd_idx[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file (index 0 hardwired to zero) with writeback bypass
// on every read port and an integrated RAW scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREGS = DEF_NREGS,
    parameter  int NREAD = DEF_NREAD,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREAD-1:0][IDXW-1:0]  rd_idx,
    output logic [NREAD-1:0][WIDTH-1:0] rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic                        iss_valid,
    input  logic [IDXW-1:0]             iss_idx,
    output logic                        iss_ready,
    input  logic                        wb_en,
    input  logic [IDXW-1:0]             wb_idx,
    input  logic [WIDTH-1:0]            wb_data,
    output logic [IDXW:0]               pend_cnt
);
    logic [NREGS-1:0][WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (wb_en && wb_idx != '0) data_d[wb_idx] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_idx[i] == '0)                       rd_data[i] = '0;
            else if (wb_en && wb_idx == rd_idx[i])     rd_data[i] = wb_data;
            else                                       rd_data[i] = data_q[rd_idx[i]];
        end
    end

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (rd_idx),
        .rd_busy   (rd_busy),
        .iss_valid (iss_valid),
        .iss_idx   (iss_idx),
        .iss_ready (iss_ready),
        .wb_en     (wb_en),
        .wb_idx    (wb_idx),
        .pend_cnt  (pend_cnt)
    );
endmodule
